nes_frame_sched: RTL and testbench
==================================

// Module: nes_frame_sched
// PURPOSE
//  Frame scheduler between the VGA timing generator, the ping-pong frame-buffer BRAM and the HLS NES core.
//  - Starts one NES emulation frame per VGA frame.
//  - Owns the buffer page select and swaps it only on completed frames.
//  - Counts frames and overruns.
//  - Runs a watchdog that resets a hung core.
// PARAMETERS
//  SYNC_STAGES  2          synchronizer depth on vga_vs (VGA domain is asynchronous)
//  TIMEOUT_CYC  4000000    max ap_clk cycles in RUN before watchdog fires (~2.4 frames)
//  TO_W         23         watchdog counter width, >= clog2(TIMEOUT_CYC+1)
//  RST_PULSE    16         core_rst pulse length, cycles
//  CNT_W        32         frame counter width
//  OVR_W        8          overrun counter width (saturating)
// PORTS
//  ap_clk      in   1      system clock; all logic on rising edge
//  ap_rst_n    in   1      asynchronous active-low reset
//  en          in   1      1 = schedule frames; 0 = finish current frame then idle
//  vga_vs      in   1      VGA vsync, active-low, asynchronous to ap_clk
//  ap_done     in   1      core done, 1-cycle pulse
//  ap_start    out  1      core start, held until ap_done
//  core_rst    out  1      active-high core reset pulse (watchdog recovery)
//  rd_page     out  1      page read by VGA; write page = ~rd_page
//  frame_cnt   out  CNT_W  completed frames, wraps
//  ovr_cnt     out  OVR_W  vsyncs seen while core busy, saturates at all-ones
//  timeout_err out  1      sticky watchdog flag, cleared only by reset
// BEHAVIOUR
//  - Reset values: all outputs 0; state IDLE; counters 0.
//  - Frame event fs = falling edge of the synchronized vga_vs.
//    - Latency from the vga_vs pin is SYNC_STAGES+1 cycles.
//  - States:
//    - IDLE: if en, goto WAIT_VS.
//    - WAIT_VS:
//      - if !en, goto IDLE.
//      - on fs: toggle rd_page, assert ap_start next cycle, goto RUN.
//    - RUN:
//      - ap_start=1; wdog counts up.
//      - On ap_done: ap_start=0 same-cycle-registered (low the cycle after done), frame_cnt+1.
//        - If fs is also seen that cycle and en=1: toggle rd_page, keep ap_start=1, stay RUN, clear wdog.
//        - Otherwise goto WAIT_VS, or IDLE if !en.
//      - fs without ap_done: ovr_cnt+1 (saturating); no page swap, no restart.
//      - wdog==TIMEOUT_CYC-1 with no done: ap_start=0, timeout_err=1, goto RECOVER.
//    - RECOVER:
//      - core_rst=1 for exactly RST_PULSE cycles, rd_page unchanged.
//      - Then goto WAIT_VS.
//  - Page invariant: rd_page changes only on fs entering RUN, so VGA never reads a half-written page.
//  - ap_done outside RUN is ignored.
//  - en deassert in RUN does not abort the frame.
//  - Async reset mid-RUN drops ap_start immediately; the core is reset by the same reset net.
// CONFIGURATION
//  FRAME_STEP_EN defined:
//    - adds input step (1 bit, synchronous) and input step_mode.
//    - When step_mode=1, WAIT_VS also requires a latched rising edge of step before starting.
//    - One step press runs exactly one frame; presses during RUN are dropped.
//  FRAME_STEP_EN undefined: ports absent, behaviour as above.
// STRUCTURE
//  - Package nes_sched_pkg: state enum {IDLE,WAIT_VS,RUN,RECOVER}, default widths, RST_PULSE width constant.
//  - One sub-module nes_sync_edge: SYNC_STAGES flop synchronizer + falling-edge pulse; it also serves the step input.
// TESTING
//  1. Reset, en=1, vga_vs falls, ap_done 1000 cycles after ap_start -> rd_page 0->1, ap_start high ~1000 cycles, frame_cnt=1.
//  2. Two vs falls before ap_done -> ovr_cnt=1, rd_page toggled once only, frame_cnt=1 after done.
//  3. ap_done and fs in same cycle -> ap_start stays 1, rd_page toggles, frame_cnt+1, ovr_cnt unchanged.
//  4. No ap_done (TIMEOUT_CYC=100) -> timeout_err=1 at cycle 100, core_rst high 16 cycles, then next fs restarts.
//  5. ovr_cnt at 8'hFF plus another overrun -> stays 8'hFF; reset asserted mid-RUN -> all outputs 0 asynchronously.
//  6. FRAME_STEP_EN, step_mode=1 -> fs alone gives no start; step pulse then fs -> exactly one frame.

Source files
------------

// File: rtl/nes_sched_pkg.sv
// Shared types and default sizing for the NES frame scheduler.
package nes_sched_pkg;

  // Scheduler states; the encoding is also what state_dbg shows.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    RUN     = 2'd2,
    RECOVER = 2'd3
  } sched_state_e;

  // Default sizing of the scheduler.
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT_CYC = 4000000;
  localparam int DEF_TO_W        = 23;
  localparam int DEF_RST_PULSE   = 16;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_OVR_W       = 8;

  // Width of the core-reset pulse counter; RST_PULSE must not exceed 2**RST_W.
  localparam int RST_W = 5;

endpackage

// File: rtl/nes_sync_edge.sv
// Multi-flop synchronizer with a falling-edge pulse on the synchronized level.
// Used for the asynchronous VGA vsync and, inverted, for the step button.
module nes_sync_edge #(
  parameter int   STAGES = 2,   // must be >= 2
  parameter logic INIT   = 1'b1 // idle level of the input, loaded at reset
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // Shift the raw input through the synchronizer and remember the last synchronized level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{INIT}};
      last_q <= INIT;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      last_q <= sync_q[STAGES-1];
    end
  end

  // One-cycle pulse when the synchronized level goes from 1 to 0.
  assign fall = last_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/nes_frame_sched.sv
// Frame scheduler between the VGA timing, the ping-pong frame buffer and the
// HLS NES core: one core frame per VGA frame, page swap on frame start,
// frame/overrun counters and a watchdog that resets a hung core.
// Optional feature macro: FRAME_STEP_EN (single-frame stepping via step/step_mode).
// Handshake: ap_start rises the cycle after a frame event is accepted and is
// held until the cycle after the core's one-cycle ap_done pulse (or a watchdog
// timeout); ap_done is only honoured while ap_start is high.
module nes_frame_sched
  import nes_sched_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int TO_W        = DEF_TO_W,
  parameter int RST_PULSE   = DEF_RST_PULSE,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int OVR_W       = DEF_OVR_W
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             en,
  input  logic             vga_vs,
  input  logic             ap_done,
`ifdef FRAME_STEP_EN
  input  logic             step,
  input  logic             step_mode,
`endif
  output logic             ap_start,
  output logic             core_rst,
  output logic             rd_page,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [OVR_W-1:0] ovr_cnt,
  output logic             timeout_err,
  output logic [1:0]       state_dbg
);

  localparam logic [TO_W-1:0]  WDOG_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_PULSE - 1);

  sched_state_e      state_q, state_d;
  logic [TO_W-1:0]   wdog_q;
  logic [RST_W-1:0]  rst_cnt_q;
  logic              fs;
  logic              step_ok;

  // Strobes decoded from the current state and inputs.
  logic start_frame;  // frame accepted: swap page, (re)start core
  logic frame_done;   // core finished a frame
  logic overrun;      // vsync arrived while the core was still busy
  logic wdog_fire;    // core hung for the full watchdog window

  // Frame event: falling edge of the synchronized active-low vsync.
  nes_sync_edge #(
    .STAGES (SYNC_STAGES),
    .INIT   (1'b1)
  ) u_vs_sync (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .din   (vga_vs),
    .fall  (fs)
  );

`ifdef FRAME_STEP_EN
  logic step_rise;
  logic step_pend_q;

  // Rising edge of step is the falling edge of its inverse.
  nes_sync_edge #(
    .STAGES (SYNC_STAGES),
    .INIT   (1'b1)
  ) u_step_sync (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .din   (~step),
    .fall  (step_rise)
  );

  // Latch one step press outside RUN; a started frame consumes it.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      step_pend_q <= 1'b0;
    end else if (start_frame) begin
      step_pend_q <= 1'b0;
    end else if (step_rise && (state_q != RUN)) begin
      step_pend_q <= 1'b1;
    end
  end

  assign step_ok = !step_mode || step_pend_q;
`else
  assign step_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode plus the datapath strobes that go with each transition.
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    frame_done  = 1'b0;
    overrun     = 1'b0;
    wdog_fire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (!en) begin
          state_d = IDLE;
        end else if (fs && step_ok) begin
          state_d     = RUN;
          start_frame = 1'b1;
        end
      end
      RUN: begin
        if (ap_done) begin
          frame_done = 1'b1;
          // A vsync landing on the done cycle starts the next frame back-to-back.
          if (fs && en && step_ok) begin
            start_frame = 1'b1;
          end else if (en) begin
            state_d = WAIT_VS;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (fs) overrun = 1'b1;
          if (wdog_q == WDOG_LAST) begin
            wdog_fire = 1'b1;
            state_d   = RECOVER;
          end
        end
      end
      RECOVER: begin
        if (rst_cnt_q == RST_LAST) state_d = WAIT_VS;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: start is held for the whole of RUN, core reset for the whole of RECOVER.
  always_comb begin
    ap_start  = (state_q == RUN);
    core_rst  = (state_q == RECOVER);
    state_dbg = state_q;
  end

  // Page select, counters, sticky timeout flag, watchdog and reset-pulse timers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_page     <= 1'b0;
      frame_cnt   <= '0;
      ovr_cnt     <= '0;
      timeout_err <= 1'b0;
      wdog_q      <= '0;
      rst_cnt_q   <= '0;
    end else begin
      if (start_frame) rd_page <= ~rd_page;
      if (frame_done) frame_cnt <= frame_cnt + CNT_W'(1);
      if (overrun && (ovr_cnt != '1)) ovr_cnt <= ovr_cnt + OVR_W'(1);
      if (wdog_fire) timeout_err <= 1'b1;
      if ((state_q != RUN) || start_frame) begin
        wdog_q <= '0;
      end else begin
        wdog_q <= wdog_q + TO_W'(1);
      end
      if (state_q != RECOVER) begin
        rst_cnt_q <= '0;
      end else begin
        rst_cnt_q <= rst_cnt_q + RST_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_nes_frame_sched.sv
// Bench for nes_frame_sched: directed stimulus, expected output snapshots
// queued by the stimulus and checked by a monitor on every output change.
module tb_nes_frame_sched;

  localparam int W       = 28;
  localparam int TIMEOUT = 1200;

  logic        clk;
  logic        ap_rst_n;
  logic        en;
  logic        vga_vs;
  logic        ap_done;
  logic        ap_start;
  logic        core_rst;
  logic        rd_page;
  logic [31:0] frame_cnt;
  logic [7:0]  ovr_cnt;
  logic        timeout_err;
  logic [1:0]  state_dbg;
`ifdef FRAME_STEP_EN
  logic        step;
  logic        step_mode;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_snap;
  logic         mon_en = 1'b0;
  int           as_cnt = 0, as_last = 0;
  int           cr_cnt = 0, cr_last = 0;

  // Model of the expected output state.
  logic        m_page = 1'b0;
  logic        m_te   = 1'b0;
  logic [7:0]  m_ovr  = 8'd0;
  logic [15:0] m_fc   = 16'd0;

  nes_frame_sched #(
    .TIMEOUT_CYC (TIMEOUT),
    .TO_W        (11)
  ) dut (
    .ap_clk      (clk),
    .ap_rst_n    (ap_rst_n),
    .en          (en),
    .vga_vs      (vga_vs),
    .ap_done     (ap_done),
`ifdef FRAME_STEP_EN
    .step        (step),
    .step_mode   (step_mode),
`endif
    .ap_start    (ap_start),
    .core_rst    (core_rst),
    .rd_page     (rd_page),
    .frame_cnt   (frame_cnt),
    .ovr_cnt     (ovr_cnt),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, required finish before 1 ms");
    $fatal(1, "bench timed out");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(input logic te, input logic cr, input logic as,
                                      input logic rp, input logic [7:0] ovr,
                                      input logic [15:0] fc);
    return {te, cr, as, rp, ovr, fc};
  endfunction

  function automatic logic [W-1:0] cur_snap();
    return {timeout_err, core_rst, ap_start, rd_page, ovr_cnt, frame_cnt[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic vs_pulse();
    vga_vs = 1'b0;
    tick(4);
    vga_vs = 1'b1;
    tick(4);
  endtask

  task automatic fast_vs_pulse();
    vga_vs = 1'b0;
    tick(2);
    vga_vs = 1'b1;
    tick(2);
  endtask

  task automatic done_pulse();
    ap_done = 1'b1;
    tick(1);
    ap_done = 1'b0;
    tick(2);
  endtask

  task automatic push_start();
    m_page = ~m_page;
    exp_q.push_back(mk(m_te, 1'b0, 1'b1, m_page, m_ovr, m_fc));
  endtask

  task automatic push_done();
    m_fc = m_fc + 16'd1;
    exp_q.push_back(mk(m_te, 1'b0, 1'b0, m_page, m_ovr, m_fc));
  endtask

  task automatic push_ovr();
    if (m_ovr != 8'hFF) begin
      m_ovr = m_ovr + 8'd1;
      exp_q.push_back(mk(m_te, 1'b0, 1'b1, m_page, m_ovr, m_fc));
    end
  endtask

  task automatic model_reset();
    m_page = 1'b0;
    m_te   = 1'b0;
    m_ovr  = 8'd0;
    m_fc   = 16'd0;
  endtask

  // Bounded wait for ap_start (which=0) or core_rst (which=1) to reach val.
  task automatic wait_level(input string name, input int which, input logic val, input int budget);
    logic ok;
    logic sig;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      sig = (which == 0) ? ap_start : core_rst;
      if (sig == val) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got no level %0b, required it within %0d cycles", name, val, budget);
    end
    tick(1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] cur;
    cur = cur_snap();
    if (mon_en && (cur !== last_snap)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_change: got %h, required no change", cur);
      end else begin
        check("out_change", 32'(cur), 32'(exp_q.pop_front()));
      end
    end
    last_snap = cur;
    if (ap_start === 1'b1) as_cnt++;
    else if (as_cnt != 0) begin as_last = as_cnt; as_cnt = 0; end
    if (core_rst === 1'b1) cr_cnt++;
    else if (cr_cnt != 0) begin cr_last = cr_cnt; cr_cnt = 0; end
  end

  // ---------------- stimulus ----------------
  initial begin
    ap_rst_n = 1'b0;
    en       = 1'b0;
    vga_vs   = 1'b1;
    ap_done  = 1'b0;
`ifdef FRAME_STEP_EN
    step      = 1'b0;
    step_mode = 1'b0;
`endif
    tick(3);
    check("reset_outputs", 32'(cur_snap()), 32'(0));
    check("reset_state", 32'(state_dbg), 32'(0));
    ap_rst_n = 1'b1;
    tick(2);
    mon_en = 1'b1;

    // 1: single frame, done 1000 cycles after start
    en = 1'b1;
    tick(2);
    check("idle_to_wait", 32'(state_dbg), 32'(1));
    push_start();
    vs_pulse();
    tick(1000);
    push_done();
    done_pulse();
    done_pulse();                // done outside RUN: no output change expected
    tick(5);

    // 2: second vsync while busy counts one overrun, no page swap
    push_start();
    vs_pulse();
    tick(20);
    push_ovr();
    vs_pulse();
    tick(20);
    push_done();
    done_pulse();

    // 3: done and frame event on the same cycle restart back-to-back
    push_start();
    vs_pulse();
    tick(30);
    m_page = ~m_page;
    m_fc   = m_fc + 16'd1;
    exp_q.push_back(mk(m_te, 1'b0, 1'b1, m_page, m_ovr, m_fc));
    vga_vs = 1'b0;
    tick(2);
    ap_done = 1'b1;
    tick(1);
    ap_done = 1'b0;
    tick(2);
    vga_vs = 1'b1;
    tick(30);
    check("b2b_running", 32'(state_dbg), 32'(2));
    push_done();
    done_pulse();

    // en dropped mid-frame: frame completes, then idle
    push_start();
    vs_pulse();
    en = 1'b0;
    tick(10);
    push_done();
    done_pulse();
    vs_pulse();
    check("en_low_idle", 32'(state_dbg), 32'(0));
    en = 1'b1;
    tick(2);

    // 4: watchdog fires, core_rst pulse, then restart on next vsync
    push_start();
    vs_pulse();
    m_te = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, m_page, m_ovr, m_fc));
    wait_level("wait_core_rst_high", 1, 1'b1, TIMEOUT + 100);
    check("wdog_run_len", 32'(as_last), 32'(TIMEOUT));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, m_page, m_ovr, m_fc));
    wait_level("wait_core_rst_low", 1, 1'b0, 40);
    tick(1);
    check("core_rst_len", 32'(cr_last), 32'(16));
    push_start();
    vs_pulse();
    tick(10);
    push_done();
    done_pulse();

    // 5: overrun counter saturates across two frames
    for (int f = 0; f < 2; f++) begin
      push_start();
      vs_pulse();
      for (int p = 0; p < 130; p++) begin
        push_ovr();
        fast_vs_pulse();
      end
      tick(6);
      push_done();
      done_pulse();
    end
    check("ovr_saturated", 32'(ovr_cnt), 32'(8'hFF));

    // async reset mid-RUN clears outputs before the next clock edge
    push_start();
    vs_pulse();
    tick(20);
    exp_q.push_back('0);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(cur_snap()), 32'(0));
    model_reset();
    tick(2);
    ap_rst_n = 1'b1;
    tick(3);

`ifdef FRAME_STEP_EN
    // 6: single-frame stepping
    step_mode = 1'b1;
    tick(2);
    vs_pulse();                  // no step latched: no start
    check("step_no_start", 32'(state_dbg), 32'(1));
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(5);
    push_start();
    vs_pulse();
    tick(5);
    step = 1'b1;                 // press during RUN is dropped
    tick(1);
    step = 1'b0;
    tick(10);
    push_done();
    done_pulse();
    vs_pulse();
    check("step_one_frame", 32'(state_dbg), 32'(1));
    step_mode = 1'b0;
`endif

    tick(5);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
